// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg : FSM state encoding and default vectors for pc_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h0000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_incr.sv
// ---------------------------------------------------------------------------
// pc_incr : combinational PC + INC, wrapping modulo 2^XLEN
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_incr #(
  parameter int          XLEN = 32,
  parameter int unsigned INC  = 4
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] sum
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INC);

  assign sum = pc + STEP;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : fetch PC register with BOOT/RUN/HALTED control and redirects
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int unsigned     INC       = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEFAULT_EXC_VEC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            if_ready_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  input  logic            exc_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic [15:0]     redirect_cnt_o
);

  // Low address bits that must be zero for a target to be INC-aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_plus;
  logic            misalign, misalign_nxt;
  logic            redirect;
  logic [15:0]     redirect_cnt;

  pc_incr #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_pc_incr (
    .pc  (pc),
    .sum (pc_plus)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_VEC;
      misalign     <= 1'b0;
      redirect_cnt <= 16'h0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= misalign_nxt;
      if (redirect && (redirect_cnt != 16'hFFFF)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    misalign_nxt = 1'b0;
    redirect     = 1'b0;
    unique case (state)
      BOOT: begin
        pc_nxt    = RESET_VEC;
        state_nxt = RUN;
      end
      RUN: begin
        if (exc_i) begin
          pc_nxt   = EXC_VEC;
          redirect = 1'b1;
        end else if (br_taken_i || jmp_i) begin
          // Branch outranks jump; a misaligned target falls back to EXC_VEC.
          redirect = 1'b1;
          if (br_taken_i) begin
            if ((br_target_i & ALIGN_MASK) == '0) begin
              pc_nxt = br_target_i;
            end else begin
              pc_nxt       = EXC_VEC;
              misalign_nxt = 1'b1;
            end
          end else if ((jmp_target_i & ALIGN_MASK) == '0) begin
            pc_nxt = jmp_target_i;
          end else begin
            pc_nxt       = EXC_VEC;
            misalign_nxt = 1'b1;
          end
        end else if (halt_i) begin
          state_nxt = HALTED;
        end else if (!stall_i && if_ready_i) begin
          pc_nxt = pc_plus;
        end
      end
      HALTED: begin
        if (exc_i) begin
          pc_nxt    = EXC_VEC;
          redirect  = 1'b1;
          state_nxt = RUN;
        end else if (resume_i) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign pc_o           = pc;
  assign pc_plus_o      = pc_plus;
  assign pc_valid_o     = (state == RUN);
  assign misalign_o     = misalign;
  assign redirect_cnt_o = redirect_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer : directed self-checking bench for pc_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall_i, if_ready_i, br_taken_i, jmp_i, exc_i, halt_i, resume_i;
  logic [XLEN-1:0] br_target_i, jmp_target_i;
  logic [XLEN-1:0] pc_o, pc_plus_o;
  logic            pc_valid_o, misalign_o;
  logic [15:0]     redirect_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN      (XLEN),
    .INC       (4),
    .RESET_VEC (32'h0000_0000),
    .EXC_VEC   (32'h0000_0180)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .if_ready_i     (if_ready_i),
    .br_taken_i     (br_taken_i),
    .br_target_i    (br_target_i),
    .jmp_i          (jmp_i),
    .jmp_target_i   (jmp_target_i),
    .exc_i          (exc_i),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .pc_o           (pc_o),
    .pc_plus_o      (pc_plus_o),
    .pc_valid_o     (pc_valid_o),
    .misalign_o     (misalign_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; if_ready_i = 1'b1; br_taken_i = 1'b0; jmp_i = 1'b0;
    exc_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0; br_target_i = '0; jmp_target_i = '0;
    tick(); tick();
    check_eq("rst_pc", pc_o, 32'h0);
    check_eq("rst_valid", {31'b0, pc_valid_o}, 32'd0);
    check_eq("rst_misalign", {31'b0, misalign_o}, 32'd0);
    check_eq("rst_cnt", {16'b0, redirect_cnt_o}, 32'd0);
    check_eq("rst_pc_plus", pc_plus_o, 32'h4);

    // Reset release: BOOT cycle, then RUN at RESET_VEC, then sequential.
    rst = 1'b0;
    tick();
    check_eq("boot_pc", pc_o, 32'h0);
    check_eq("boot_valid", {31'b0, pc_valid_o}, 32'd1);
    tick();
    check_eq("seq_pc", pc_o, 32'h4);

    // Branch beats stall.
    stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h100;
    tick();
    check_eq("br_stall_pc", pc_o, 32'h100);
    check_eq("br_stall_cnt", {16'b0, redirect_cnt_o}, 32'd1);
    br_taken_i = 1'b0;
    tick();
    check_eq("stall_hold", pc_o, 32'h100);
    stall_i = 1'b0;
    tick();
    check_eq("unstall_pc", pc_o, 32'h104);

    // Misaligned jump.
    jmp_i = 1'b1; jmp_target_i = 32'h102;
    tick();
    check_eq("misjmp_pc", pc_o, 32'h180);
    check_eq("misjmp_pulse", {31'b0, misalign_o}, 32'd1);
    check_eq("misjmp_cnt", {16'b0, redirect_cnt_o}, 32'd2);
    jmp_i = 1'b0;
    tick();
    check_eq("misjmp_pulse_end", {31'b0, misalign_o}, 32'd0);
    check_eq("misjmp_next", pc_o, 32'h184);

    // Exception and branch together.
    exc_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h200;
    tick();
    check_eq("exc_br_pc", pc_o, 32'h180);
    check_eq("exc_br_cnt", {16'b0, redirect_cnt_o}, 32'd3);
    exc_i = 1'b0; br_taken_i = 1'b0;
    tick();
    check_eq("exc_br_next", pc_o, 32'h184);

    // Halt/resume at the top of the address space, then wrap.
    jmp_i = 1'b1; jmp_target_i = 32'hFFFF_FFFC;
    tick();
    check_eq("jmp_top_pc", pc_o, 32'hFFFF_FFFC);
    check_eq("jmp_top_misalign", {31'b0, misalign_o}, 32'd0);
    check_eq("top_pc_plus", pc_plus_o, 32'h0);
    jmp_i = 1'b0; halt_i = 1'b1;
    tick();
    check_eq("halt_pc", pc_o, 32'hFFFF_FFFC);
    check_eq("halt_valid", {31'b0, pc_valid_o}, 32'd0);
    halt_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h300;
    tick();
    check_eq("halt_br_ignored", pc_o, 32'hFFFF_FFFC);
    check_eq("halt_br_cnt", {16'b0, redirect_cnt_o}, 32'd4);
    check_eq("halt_valid2", {31'b0, pc_valid_o}, 32'd0);
    br_taken_i = 1'b0; resume_i = 1'b1;
    tick();
    check_eq("resume_pc", pc_o, 32'hFFFF_FFFC);
    check_eq("resume_valid", {31'b0, pc_valid_o}, 32'd1);
    resume_i = 1'b0;
    tick();
    check_eq("wrap_pc", pc_o, 32'h0);
    check_eq("wrap_misalign", {31'b0, misalign_o}, 32'd0);

    // Memory back-pressure for three cycles.
    if_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_pc", pc_o, 32'h0);
      check_eq("bp_valid", {31'b0, pc_valid_o}, 32'd1);
    end
    if_ready_i = 1'b1;
    tick();
    check_eq("bp_release", pc_o, 32'h4);

    // Exception while HALTED wins over resume.
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0; exc_i = 1'b1; resume_i = 1'b1;
    tick();
    check_eq("halt_exc_pc", pc_o, 32'h180);
    check_eq("halt_exc_valid", {31'b0, pc_valid_o}, 32'd1);
    check_eq("halt_exc_cnt", {16'b0, redirect_cnt_o}, 32'd5);
    exc_i = 1'b0; resume_i = 1'b0;
    tick();
    check_eq("halt_exc_next", pc_o, 32'h184);

    // Reset overrides a redirect in the same cycle.
    rst = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h400;
    tick();
    check_eq("rst_mid_pc", pc_o, 32'h0);
    check_eq("rst_mid_valid", {31'b0, pc_valid_o}, 32'd0);
    check_eq("rst_mid_cnt", {16'b0, redirect_cnt_o}, 32'd0);
    br_taken_i = 1'b0;

    // Counter saturation via back-to-back exceptions.
    rst = 1'b0; exc_i = 1'b1;
    tick();
    check_eq("sat_boot_cnt", {16'b0, redirect_cnt_o}, 32'd0);
    for (int i = 0; i < 65534; i++) tick();
    check_eq("sat_pre_cnt", {16'b0, redirect_cnt_o}, 32'd65534);
    tick();
    check_eq("sat_cnt", {16'b0, redirect_cnt_o}, 32'd65535);
    tick();
    check_eq("sat_hold_cnt", {16'b0, redirect_cnt_o}, 32'd65535);
    exc_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
